kb_seq_ctrl: RTL

KB_SEQ_CTRL -- requirements
Module: kb_seq_ctrl

---
 rtl/kb_seq_ctrl.sv | 104 ++++++++++
 1 files changed

// File: rtl/kb_seq_ctrl.sv
// PS/2 scan-code sequencer: pops codes from a keyboard buffer, tracks break/extended
// prefixes and shift state, and presents decoded make codes on a valid/ready output.
module kb_seq_ctrl #(
  parameter logic [7:0] BREAK_CODE = 8'hF0,
  parameter logic [7:0] EXT_CODE   = 8'hE0,
  parameter logic [7:0] SHIFT_L    = 8'h12,
  parameter logic [7:0] SHIFT_R    = 8'h59,
  parameter bit         REPEAT_EN  = 1'b0
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic       kb_buf_empty,
  input  logic [7:0] key_code,
  input  logic [7:0] ascii_in,
  output logic       rd_key_code,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_ascii,
  output logic [7:0] out_scan,
  output logic       out_ext,
  output logic       shift_on
);

  typedef enum logic [1:0] {IDLE, FETCH, SETTLE} state_t;

  state_t     state, state_next;
  logic [7:0] code_r, asc_r, last_make, asc_adj;
  logic       shift_l, shift_r, brk, ext;
  logic       is_shift;

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= state_next;
  end

  // A new pop is only started while nothing is waiting on the output.
  always_comb begin
    state_next  = state;
    rd_key_code = 1'b0;
    case (state)
      IDLE:    if (!kb_buf_empty && !out_valid) state_next = FETCH;
      FETCH: begin
        rd_key_code = 1'b1;
        state_next  = SETTLE;
      end
      SETTLE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign shift_on = shift_l | shift_r;
  assign is_shift = (code_r == SHIFT_L) || (code_r == SHIFT_R);

  always_comb begin
    asc_adj = asc_r;
    if (shift_on && (asc_r >= 8'h61) && (asc_r <= 8'h7A)) asc_adj = asc_r - 8'h20;
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      code_r    <= 8'h00;
      asc_r     <= 8'h00;
      out_valid <= 1'b0;
      out_ascii <= 8'h00;
      out_scan  <= 8'h00;
      out_ext   <= 1'b0;
      shift_l   <= 1'b0;
      shift_r   <= 1'b0;
      brk       <= 1'b0;
      ext       <= 1'b0;
      last_make <= 8'h00;
    end else begin
      if (state == FETCH) begin
        code_r <= key_code;
        asc_r  <= ascii_in;
      end
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (state == SETTLE) begin
        if (code_r == BREAK_CODE) begin
          brk <= 1'b1;
        end else if (code_r == EXT_CODE) begin
          ext <= 1'b1;
        end else begin
          brk <= 1'b0;
          ext <= 1'b0;
          // An E0-prefixed shift make is not a real shift and is decoded as a key.
          if (is_shift && (brk || !ext)) begin
            if (code_r == SHIFT_L) shift_l <= !brk;
            else                   shift_r <= !brk;
          end else if (brk) begin
            if (code_r == last_make) last_make <= 8'h00;
          end else if (REPEAT_EN || (code_r != last_make)) begin
            out_valid <= 1'b1;
            out_ascii <= asc_adj;
            out_scan  <= code_r;
            out_ext   <= ext;
            last_make <= code_r;
          end
        end
      end
    end
  end

endmodule
